// File: rtl/ahb3lite_sram_ws_if.sv
// AHB3-Lite bus bundle between a master/interconnect and the wait-state SRAM slave.
// HREADY is the interconnect's combined ready, driven on the master side.
interface ahb3lite_sram_ws_if #(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32
);
   logic                  HSEL;
   logic [HADDR_SIZE-1:0] HADDR;
   logic [HDATA_SIZE-1:0] HWDATA;
   logic [HDATA_SIZE-1:0] HRDATA;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [2:0]            HBURST;
   logic [3:0]            HPROT;
   logic [1:0]            HTRANS;
   logic                  HREADY;
   logic                  HREADYOUT;
   logic                  HRESP;

   modport master (
      output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite SRAM slave: WAIT_STATES stall cycles per data phase, byte-lane writes, write-to-read forwarding.
// Define AHB3LITE_SRAM_WS_ERR_EN to answer illegal transfers with a two-cycle ERROR response.
module ahb3lite_sram_ws #(
   parameter int MEM_DEPTH   = 256,
   parameter int HADDR_SIZE  = 32,
   parameter int HDATA_SIZE  = 32,
   parameter int WAIT_STATES = 0
) (
   input logic               HCLK,
   input logic               HRESET,
   ahb3lite_sram_ws_if.slave bus
);
   localparam int         BE       = HDATA_SIZE / 8;
   localparam int         ADDR_LSB = $clog2(BE);
   localparam int         MEM_AW   = $clog2(MEM_DEPTH);
   localparam logic [2:0] WS_LOAD  = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_LAST,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [MEM_AW-1:0]     addr_q, addr_d;
   logic [BE-1:0]         be_q, be_d;
   logic                  write_q, write_d;
   logic [HDATA_SIZE-1:0] rdata_q, rdata_d;

   logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

   logic                  in_ready_state;
   logic                  accept;
   logic                  illegal;
   logic                  wr_commit;
   logic                  rd_load;
   logic [MEM_AW-1:0]     bus_word;
   logic [BE-1:0]         bus_be;
   logic [HADDR_SIZE-1:0] byte_off;
   logic                  unused_bits;

   assign in_ready_state = (state_q == ST_IDLE) | (state_q == ST_LAST) | (state_q == ST_ERR2);
   assign accept         = bus.HSEL & bus.HREADY & bus.HTRANS[1] & in_ready_state;
   assign bus_word       = bus.HADDR[ADDR_LSB +: MEM_AW];
   assign byte_off       = bus.HADDR & HADDR_SIZE'(BE - 1);
   assign unused_bits    = ^{bus.HBURST, bus.HPROT, bus.HADDR};

   // Lanes covered by the transfer size, starting at the byte offset; oversize is capped to the bus.
   always_comb begin
      int sz;
      int off;
      sz     = (32'(bus.HSIZE) > ADDR_LSB) ? (1 << ADDR_LSB) : (1 << bus.HSIZE);
      off    = int'(byte_off);
      bus_be = '0;
      for (int i = 0; i < BE; i++) begin
         bus_be[i] = (i >= off) && (i < off + sz);
      end
   end

`ifdef AHB3LITE_SRAM_WS_ERR_EN
   logic [HADDR_SIZE-1:0] align_mask;
   assign align_mask = (HADDR_SIZE'(1) << bus.HSIZE) - HADDR_SIZE'(1);
   assign illegal    = ({1'b0, bus.HADDR} >= (HADDR_SIZE + 1)'(MEM_DEPTH * BE))
                     | (32'(bus.HSIZE) > ADDR_LSB)
                     | ((bus.HADDR & align_mask) != '0);
   assign bus.HRESP  = (state_q == ST_ERR1) | (state_q == ST_ERR2);
`else
   assign illegal    = 1'b0;
   assign bus.HRESP  = 1'b0;
`endif

   assign bus.HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
   assign bus.HRDATA    = rdata_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      be_d    = be_q;
      write_d = write_q;
      case (state_q)
         ST_WAIT: begin
            if (cnt_q == 3'd0) state_d = ST_LAST;
            else               cnt_d   = cnt_q - 3'd1;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            state_d = ST_IDLE;
            if (accept) begin
               if (illegal) begin
                  state_d = ST_ERR1;
               end else begin
                  addr_d  = bus_word;
                  be_d    = bus_be;
                  write_d = bus.HWRITE;
                  if (WAIT_STATES > 0) begin
                     state_d = ST_WAIT;
                     cnt_d   = WS_LOAD;
                  end else begin
                     state_d = ST_LAST;
                  end
               end
            end
         end
      endcase
   end

   assign wr_commit = (state_q == ST_LAST) & write_q;
   assign rd_load   = (state_d == ST_LAST) & ~write_d;

   // A write finishing on the same edge the read loads is merged so the read sees post-write data.
   always_comb begin
      rdata_d = rdata_q;
      if (rd_load) begin
         rdata_d = mem[addr_d];
         if (wr_commit && (addr_q == addr_d)) begin
            for (int i = 0; i < BE; i++) begin
               if (be_q[i]) rdata_d[8*i +: 8] = bus.HWDATA[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge HCLK) begin
      if (wr_commit) begin
         for (int i = 0; i < BE; i++) begin
            if (be_q[i]) mem[addr_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Drives a zero-wait and a two-wait instance of ahb3lite_sram_ws with directed and random
// pipelined transfers and compares against a byte-addressed memory model.
module tb_ahb3lite_sram_ws;
   localparam int WS0 = 0;
   localparam int WS1 = 2;
`ifdef AHB3LITE_SRAM_WS_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        hsel   [2];
   logic        hwrite [2];
   logic [31:0] haddr  [2];
   logic [31:0] hwdata [2];
   logic [2:0]  hsize  [2];
   logic [1:0]  htrans [2];

   ahb3lite_sram_ws_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus0 ();
   ahb3lite_sram_ws_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus1 ();

   assign bus0.HSEL   = hsel[0];
   assign bus0.HWRITE = hwrite[0];
   assign bus0.HADDR  = haddr[0];
   assign bus0.HWDATA = hwdata[0];
   assign bus0.HSIZE  = hsize[0];
   assign bus0.HTRANS = htrans[0];
   assign bus0.HBURST = 3'b000;
   assign bus0.HPROT  = 4'b0011;
   assign bus0.HREADY = bus0.HREADYOUT;

   assign bus1.HSEL   = hsel[1];
   assign bus1.HWRITE = hwrite[1];
   assign bus1.HADDR  = haddr[1];
   assign bus1.HWDATA = hwdata[1];
   assign bus1.HSIZE  = hsize[1];
   assign bus1.HTRANS = htrans[1];
   assign bus1.HBURST = 3'b000;
   assign bus1.HPROT  = 4'b0011;
   assign bus1.HREADY = bus1.HREADYOUT;

   ahb3lite_sram_ws #(.MEM_DEPTH(256), .HADDR_SIZE(32), .HDATA_SIZE(32), .WAIT_STATES(WS0)) dut0 (
      .HCLK(clk), .HRESET(rst), .bus(bus0));
   ahb3lite_sram_ws #(.MEM_DEPTH(256), .HADDR_SIZE(32), .HDATA_SIZE(32), .WAIT_STATES(WS1)) dut1 (
      .HCLK(clk), .HRESET(rst), .bus(bus1));

   int checks   = 0;
   int failures = 0;

   // Command list for one run and what was observed for each entry.
   bit          cw     [64];
   logic [31:0] ca     [64];
   logic [2:0]  cs     [64];
   logic [31:0] cd     [64];
   logic [31:0] rr     [64];
   int          rstall [64];
   int          rresp  [64];
   int          ncmd;

   // Reference model: byte-addressed memory plus the last value a legal read returned.
   logic [7:0]  mb      [2][1024];
   logic [31:0] last_rd [2];

   function automatic int ws(input int d);
      return (d == 0) ? WS0 : WS1;
   endfunction

   function automatic logic get_rdy(input int d);
      return (d == 0) ? bus0.HREADYOUT : bus1.HREADYOUT;
   endfunction

   function automatic logic get_resp(input int d);
      return (d == 0) ? bus0.HRESP : bus1.HRESP;
   endfunction

   function automatic logic [31:0] get_rdata(input int d);
      return (d == 0) ? bus0.HRDATA : bus1.HRDATA;
   endfunction

   function automatic bit is_illegal(input logic [31:0] a, input logic [2:0] s);
      logic [31:0] amask;
      amask = (32'd1 << s) - 32'd1;
      return ERR_EN && ((a >= 32'd1024) || (s > 3'd2) || ((a & amask) != 32'd0));
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) % 32'd256);
   endfunction

   function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
      int w;
      w = word_of(a);
      return {mb[d][w*4+3], mb[d][w*4+2], mb[d][w*4+1], mb[d][w*4]};
   endfunction

   task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] s,
                              input logic [31:0] dat);
      int w;
      int off;
      int nb;
      w   = word_of(a);
      off = int'(a % 32'd4);
      nb  = (s > 3'd2) ? 4 : (1 << s);
      for (int k = 0; k < nb; k++) begin
         if (off + k < 4) mb[d][w*4 + off + k] = dat[8*(off+k) +: 8];
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic add(input bit w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] dat);
      cw[ncmd] = w;
      ca[ncmd] = a;
      cs[ncmd] = s;
      cd[ncmd] = dat;
      ncmd++;
   endtask

   // Issues the command list back to back; entered and left just after a falling edge.
   task automatic run(input int d);
      int pres;
      int idat;
      int inext;
      int guard;
      bit rdy_prev;
      bit rdy;
      pres = -1; idat = -1; inext = 0; guard = 0; rdy_prev = 1'b1;
      for (int i = 0; i < ncmd; i++) begin
         rr[i] = 'x; rstall[i] = 0; rresp[i] = 0;
      end
      forever begin
         if (rdy_prev) begin
            idat = pres;
            if (inext < ncmd) begin
               pres = inext;
               inext++;
            end else begin
               pres = -1;
            end
         end
         if (pres < 0 && idat < 0) break;
         if (guard > 400) begin
            check("run_timeout", 32'(guard), 32'd0);
            break;
         end
         if (pres >= 0) begin
            hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = ca[pres];
            hwrite[d] = cw[pres]; hsize[d] = cs[pres];
         end else begin
            hsel[d] = 1'b0; htrans[d] = 2'b00;
         end
         hwdata[d] = (idat >= 0) ? cd[idat] : 32'h0;
         rdy = get_rdy(d);
         if (idat >= 0) begin
            if (!rdy) rstall[idat]++;
            if (get_resp(d)) rresp[idat]++;
            if (rdy && !cw[idat]) rr[idat] = get_rdata(d);
         end
         rdy_prev = rdy;
         guard++;
         @(negedge clk);
      end
      hsel[d] = 1'b0; htrans[d] = 2'b00;
   endtask

   task automatic check_run(input int d, input string tag);
      for (int i = 0; i < ncmd; i++) begin
         bit          ill;
         logic [31:0] exp;
         ill = is_illegal(ca[i], cs[i]);
         check($sformatf("%s_d%0d_%0d_stall", tag, d, i), 32'(rstall[i]), ill ? 32'd1 : 32'(ws(d)));
         check($sformatf("%s_d%0d_%0d_resp", tag, d, i), 32'(rresp[i]), ill ? 32'd2 : 32'd0);
         if (cw[i]) begin
            if (!ill) model_write(d, ca[i], cs[i], cd[i]);
         end else begin
            exp = ill ? last_rd[d] : model_word(d, ca[i]);
            if (!ill) last_rd[d] = exp;
            check($sformatf("%s_d%0d_%0d_rdata", tag, d, i), rr[i], exp);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [2:0]  s;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         hsel[d] = 1'b0; hwrite[d] = 1'b0; haddr[d] = '0; hwdata[d] = '0;
         hsize[d] = 3'd2; htrans[d] = 2'b00; last_rd[d] = '0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset_hreadyout_d%0d", d), 32'(get_rdy(d)), 32'd1);
         check($sformatf("reset_hresp_d%0d", d), 32'(get_resp(d)), 32'd0);
         check($sformatf("reset_hrdata_d%0d", d), get_rdata(d), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Preload the low 16 words of both memories.
      for (int d = 0; d < 2; d++) begin
         ncmd = 0;
         for (int i = 0; i < 16; i++) add(1'b1, 32'(i * 4), 3'd2, $urandom);
         run(d);
         check_run(d, "fill");
      end

      ncmd = 0;
      add(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
      add(1'b0, 32'h10, 3'd2, 32'h0);
      run(1);
      check_run(1, "ws2");
      check("ws2_const", rr[1], 32'hDEADBEEF);

      ncmd = 0;
      add(1'b1, 32'h20, 3'd2, 32'h11223344);
      add(1'b1, 32'h21, 3'd0, 32'h0000AA00);
      add(1'b0, 32'h20, 3'd2, 32'h0);
      run(0);
      check_run(0, "fwd");
      check("fwd_const", rr[2], 32'h1122AA44);

      for (int d = 0; d < 2; d++) begin
         ncmd = 0;
         add(1'b1, 32'h04, 3'd2, 32'h0);
         add(1'b1, 32'h06, 3'd1, 32'hBEEF0000);
         add(1'b0, 32'h04, 3'd2, 32'h0);
         run(d);
         check_run(d, "half");
         check($sformatf("half_const_d%0d", d), rr[2], 32'hBEEF0000);
      end

      // Reset while a write to 0x30 sits in its wait states.
      hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h30; hwrite[1] = 1'b1; hsize[1] = 3'd2;
      @(negedge clk);
      hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'hCAFEF00D;
      check("rst_pre_wait", 32'(get_rdy(1)), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_mid_hreadyout", 32'(get_rdy(1)), 32'd1);
      check("rst_mid_hresp", 32'(get_resp(1)), 32'd0);
      check("rst_mid_hrdata", get_rdata(1), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
      @(negedge clk);
      ncmd = 0;
      add(1'b0, 32'h30, 3'd2, 32'h0);
      run(1);
      check_run(1, "rst_rd");

      for (int d = 0; d < 2; d++) begin
         ncmd = 0;
`ifdef AHB3LITE_SRAM_WS_ERR_EN
         add(1'b1, 32'h400, 3'd2, 32'h12345678);
         add(1'b0, 32'h00, 3'd2, 32'h0);
         add(1'b0, 32'h02, 3'd2, 32'h0);
`else
         add(1'b0, 32'h400, 3'd2, 32'h0);
`endif
         run(d);
         check_run(d, "range");
      end

      for (int d = 0; d < 2; d++) begin
         for (int b = 0; b < 4; b++) begin
            ncmd = 0;
            for (int i = 0; i < 16; i++) begin
               s = 3'($urandom_range(0, 2));
               a = 32'($urandom_range(0, 63));
               if ($urandom_range(0, 7) == 0) a = a | 32'h400;
               if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
               add(1'($urandom_range(0, 1)), a, s, $urandom);
            end
            run(d);
            check_run(d, $sformatf("rand%0d", b));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
